// File: rtl/shift_div16.sv
// Radix-2 restoring shift-subtract divider, 16-bit unsigned, fixed 17-cycle latency.
// Define SHIFT_DIV16_REM_EN to drive the remainder on r; otherwise r is tied to zero.
module shift_div16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y,
    output logic [15:0] r,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]  state_reg;
    logic [4:0]  cnt_reg;
    logic [15:0] dvd_reg;
    logic [15:0] dvs_reg;
    logic [16:0] pr_reg;
    logic [15:0] quo_reg;
    logic        zero_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        dbz_reg;
    logic [15:0] y_reg;

    logic [16:0] pr_shift;
    logic [16:0] pr_diff;
    logic        pr_ge;

    always_comb begin
        pr_shift = {pr_reg[15:0], dvd_reg[15]};
        pr_ge    = (pr_shift >= {1'b0, dvs_reg});
        pr_diff  = pr_shift - {1'b0, dvs_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            pr_reg    <= '0;
            quo_reg   <= '0;
            zero_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            y_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (b != 16'd0) begin
                            dvd_reg   <= a;
                            dvs_reg   <= b;
                            pr_reg    <= '0;
                            quo_reg   <= '0;
                            cnt_reg   <= '0;
                            zero_reg  <= 1'b0;
                            dbz_reg   <= 1'b0;
                            state_reg <= ST_RUN;
                        end else begin
                            // Divide-by-zero: stage the saturated result and go straight to FIN.
                            quo_reg   <= 16'hFFFF;
                            pr_reg    <= {1'b0, a};
                            zero_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
                    dvd_reg <= {dvd_reg[14:0], 1'b0};
                    if (pr_ge) begin
                        pr_reg  <= pr_diff;
                        quo_reg <= {quo_reg[14:0], 1'b1};
                    end else begin
                        pr_reg  <= pr_shift;
                        quo_reg <= {quo_reg[14:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd15) begin
                        state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    y_reg     <= quo_reg;
                    dbz_reg   <= zero_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT_DIV16_REM_EN
    logic [15:0] r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
        end else if (state_reg == ST_FIN) begin
            r_reg <= pr_reg[15:0];
        end
    end

    assign r = r_reg;
`else
    assign r = 16'd0;
`endif

    assign y    = y_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign dbz  = dbz_reg;

endmodule

// File: doc/shift_div16.md
SHIFT_DIV16 -- requirements
Module: shift_div16

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have port: start  input  1  request a division; sampled on rising clk.
REQ-004 SHALL have port: a  input  16  unsigned dividend; sampled only when start is accepted.
REQ-005 SHALL have port: b  input  16  unsigned divisor; sampled only when start is accepted.
REQ-006 SHALL have port: y  output  16  unsigned quotient, registered.
REQ-007 SHALL have port: r  output  16  unsigned remainder, registered.
REQ-008 SHALL have port: busy  output  1  division in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when y/r/dbz are updated.
REQ-010 SHALL have port: dbz  output  1  last accepted operation had b == 0.

Function
REQ-011 SHALL implement a radix-2 restoring shift-subtract divider with states IDLE, RUN and FIN.
REQ-012 SHALL accept start only when busy == 0; start while busy == 1 is ignored, with no effect on operands or counters.
REQ-013 On acceptance with b != 0, SHALL latch a and b, clear the 17-bit partial remainder and quotient shift registers, set busy = 1 and enter RUN.
REQ-014 RUN SHALL execute one iteration per clk: pr' = {pr[15:0], dividend MSB}; dividend shifts left; if pr' >= {1'b0, divisor} then pr' -= divisor and quotient bit = 1, else quotient bit = 0, shifted in at the LSB.
REQ-015 RUN SHALL last exactly 16 clks, counted by a 5-bit iteration counter, then enter FIN.
REQ-016 FIN SHALL last 1 clk, load y = quotient and r = pr[15:0], set done = 1, set busy = 0, and return to IDLE.
REQ-017 Latency SHALL be fixed: with start accepted at edge 0, iterations occur at edges 1..16 and done is high for the cycle following edge 17.
REQ-018 On acceptance with b == 0, SHALL skip RUN: at the next edge load y = 16'hFFFF, r = a and dbz = 1, and pulse done.
REQ-019 dbz SHALL be cleared when a later start with b != 0 is accepted.
REQ-020 y, r and dbz SHALL hold their last values between done pulses and SHALL NOT change during RUN.
REQ-021 start asserted in the cycle done is high SHALL be accepted (back-to-back, no idle gap).
REQ-022 Changes on a or b after acceptance SHALL NOT affect the running operation.
REQ-023 done SHALL be high for exactly one cycle per accepted start.

Reset
REQ-024 rst_n low SHALL immediately force state = IDLE, busy = 0, done = 0, dbz = 0, y = 0, r = 0, and clear all internal registers.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-026 Macro SHIFT_DIV16_REM_EN defined SHALL cause r to carry the remainder as specified above.
REQ-027 Without SHIFT_DIV16_REM_EN, r SHALL be constant 0, the remainder output register SHALL be omitted, and REQ-018 SHALL still set y = 16'hFFFF and dbz = 1; quotient, latency and handshake SHALL be unchanged.

Verification
REQ-028 a = 100, b = 7, start at edge 0 -> busy high at edges 1..16; done after edge 17 with y = 14, r = 2, dbz = 0.
REQ-029 a = 16'hFFFF, b = 1, followed by a = 16'h1234, b = 16'hFFFF with start held high during the done cycle -> y = 16'hFFFF, r = 0, then y = 0, r = 16'h1234, with no idle cycle between operations.
REQ-030 a = 5, b = 0 -> done one cycle after acceptance, y = 16'hFFFF, r = 5, dbz = 1; then a = 9, b = 3 -> y = 3, r = 0, dbz = 0.
REQ-031 start and new a/b pulsed at edge 5 of a running 200/9 division -> ignored; result y = 22, r = 2 with unchanged latency.
REQ-032 rst_n low at edge 8 of a running division -> all outputs 0 immediately, no done pulse; a next start with a = 50, b = 5 -> y = 10, r = 0.
REQ-033 Build without SHIFT_DIV16_REM_EN, a = 100, b = 7 -> y = 14, r = 0, same done timing.
